tsc_fetch_unit: RTL
===================

// Module: tsc_fetch_unit
// PURPOSE
//  Instruction fetch stage upstream of the single-cycle TSC CPU datapath (registers/control/alu).
//  Owns the program counter, issues reads to instruction memory, and buffers the returned word.
//  Presents the word to decode with a valid/ready handshake, applies JMP redirects and counts retired instructions.
// PARAMETERS
//  WORD_SIZE  16      instruction/address width
//  RESET_PC   16'h0   PC value loaded on reset
//  TIMEOUT    15      max WAIT cycles without imem_rvalid before fetch error (1..255)
// PORTS
//  clk           in   1          clock, all state on rising edge
//  reset_cpu     in   1          asynchronous, active-high reset
//  cpu_enable    in   1          run enable; low = no new requests, no transfers
//  imem_req      out  1          one-cycle read request to instruction memory
//  imem_addr     out  WORD_SIZE  read address (= pc), valid while imem_req=1
//  imem_rvalid   in   1          read data valid, sampled only in WAIT
//  imem_rdata    in   WORD_SIZE  instruction word, captured when imem_rvalid=1 in WAIT
//  inst          out  WORD_SIZE  buffered instruction for decode
//  inst_valid    out  1          inst holds an unconsumed instruction
//  inst_ready    in   1          decode accepts inst this cycle
//  jmp           in   1          decode's Jump for the presented inst; qualified by transfer
//  jmp_target    in   12         TSC JMP target field inst[11:0]
//  pc            out  WORD_SIZE  address of the instruction on inst / next to fetch
//  PC_below8bit  out  8          pc[7:0], for LED output
//  num_inst      out  WORD_SIZE  count of transferred instructions
//  fetch_err     out  1          sticky timeout flag
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0,
//   num_inst=0, fetch_err=0, timeout counter=0. Any response arriving later is ignored.
//  Transfer = inst_valid & inst_ready & cpu_enable (single definition used everywhere).
//  States:
//   IDLE: outputs quiet. cpu_enable=1 -> REQ next cycle.
//   REQ : imem_req=1, imem_addr=pc for exactly one cycle -> WAIT (unconditional).
//   WAIT: counter increments each cycle; imem_rvalid=1 -> inst<=imem_rdata, inst_valid<=1,
//         counter<=0, -> HOLD. Counter reaching TIMEOUT without rvalid -> ERR, fetch_err<=1.
//         cpu_enable low does not cancel the outstanding read; capture still occurs.
//   HOLD: inst, pc, inst_valid stable. On transfer: inst_valid<=0, num_inst<=num_inst+1,
//         pc<=jmp ? {pc[15:12],jmp_target} : pc+1; -> REQ if cpu_enable else IDLE
//         (cpu_enable is 1 by definition of transfer, so -> REQ).
//   ERR : imem_req=0, inst_valid=0, holds until reset_cpu.
//  Latency: request to inst_valid = 1 + memory latency cycles; min instruction period 3 cycles
//   (REQ, WAIT, HOLD with rvalid in first WAIT cycle and inst_ready=1).
//  jmp/jmp_target ignored when no transfer occurs that cycle.
//  Arithmetic: pc+1 wraps 16'hFFFF->16'h0000; num_inst wraps modulo 2^16; no saturation.
//  imem_rvalid outside WAIT ignored; imem_rdata never sampled outside WAIT.
//  PC_below8bit = pc[7:0] combinationally.
// TESTING
//  1 Reset, enable, 1-cycle memory holding TSC program, inst_ready=1 -> addrs 0,1,2; inst=16'h6000 at pc=0; num_inst=3 after 3 transfers.
//  2 inst_ready=0 for 4 cycles in HOLD -> inst/pc stable, imem_req stays 0, num_inst unchanged.
//  3 pc=16 inst=16'h9015, jmp=1, jmp_target=12'h015 on transfer -> next imem_addr=16'h0015, PC_below8bit=8'h15.
//  4 cpu_enable low during WAIT, 3-cycle memory -> rdata captured, inst_valid=1, no transfer until enable returns.
//  5 No rvalid for TIMEOUT cycles -> fetch_err=1, ERR, imem_req=0 until reset_cpu.
//  6 reset_cpu pulsed mid-WAIT, late rvalid -> outputs at reset values immediately, pc=RESET_PC, response ignored; RESET_PC=16'hFFFF run -> second addr 16'h0000.

Source files
------------

// File: rtl/tsc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tsc_fetch_unit
//
// Instruction fetch stage that sits in front of the single-cycle TSC datapath.
// It owns the program counter and issues one read at a time to instruction
// memory. It buffers the returned word and presents it to decode with a
// valid/ready handshake. It also applies JMP redirects and counts the
// instructions handed to decode.
//
// Fetch sequence: IDLE -> REQ (one-cycle request) -> WAIT (until read data or
// timeout) -> HOLD (word presented until accepted) -> REQ ...
// A read that never returns parks the unit in ERR with a sticky error flag.
// Only reset_cpu leaves ERR.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset_cpu     asynchronous, active-high reset
//   cpu_enable    run enable; low blocks new requests and transfers
//   imem_req      one-cycle read request to instruction memory
//   imem_addr     read address (the pc), meaningful while imem_req=1
//   imem_rvalid   read data valid, only looked at in WAIT
//   imem_rdata    instruction word, captured when imem_rvalid=1 in WAIT
//   inst          buffered instruction for decode
//   inst_valid    inst holds an instruction decode has not yet taken
//   inst_ready    decode accepts inst this cycle
//   jmp           decode's Jump decision for the presented inst
//   jmp_target    TSC JMP target field (inst[11:0])
//   pc            address of the instruction on inst / next to fetch
//   PC_below8bit  pc[7:0], drives the LED display
//   num_inst      count of instructions transferred to decode (wraps)
//   fetch_err     sticky read-timeout flag
// -----------------------------------------------------------------------------
module tsc_fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter int                   TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset_cpu,
    input  logic                 cpu_enable,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] inst,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    input  logic                 jmp,
    input  logic [11:0]          jmp_target,
    output logic [WORD_SIZE-1:0] pc,
    output logic [7:0]           PC_below8bit,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 fetch_err
);

    // Fetch state encoding.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [WORD_SIZE-1:0] WORD_ONE    = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam logic [7:0]           TIMEOUT_CNT = 8'(TIMEOUT);

    logic [2:0]           state_q,      state_d;
    logic [WORD_SIZE-1:0] pc_q,         pc_d;
    logic [WORD_SIZE-1:0] inst_q,       inst_d;
    logic                 inst_valid_q, inst_valid_d;
    logic [WORD_SIZE-1:0] num_inst_q,   num_inst_d;
    logic                 fetch_err_q,  fetch_err_d;
    logic [7:0]           tmo_cnt_q,    tmo_cnt_d;

    // A handshake completes only when decode is ready and the CPU is running.
    // inst_valid_q is set only in HOLD, so this cannot fire in other states.
    logic transfer;
    assign transfer = inst_valid_q & inst_ready & cpu_enable;

    // JMP keeps the upper pc bits and replaces the low 12 with the target.
    // Sequential fetch wraps 16'hFFFF -> 16'h0000 naturally.
    logic [WORD_SIZE-1:0] pc_next;
    assign pc_next = jmp ? {pc_q[WORD_SIZE-1:12], jmp_target} : pc_q + WORD_ONE;

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every variable assigned in this block first gets its held value.
        // Without these defaults a path that skips an assignment would infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        num_inst_d   = num_inst_q;
        fetch_err_d  = fetch_err_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_enable) begin
                    state_d = S_REQ;
                end
            end

            // The request lasts exactly one cycle. The memory is committed once
            // asked, so disabling the CPU here does not abort the read.
            S_REQ: begin
                tmo_cnt_d = 8'd0;
                state_d   = S_WAIT;
            end

            // Data arriving on the last allowed cycle still wins over the timeout.
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    tmo_cnt_d    = 8'd0;
                    state_d      = S_HOLD;
                end else if (tmo_cnt_q + 8'd1 == TIMEOUT_CNT) begin
                    tmo_cnt_d   = tmo_cnt_q + 8'd1;
                    fetch_err_d = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end

            // A transfer implies cpu_enable=1, so the next fetch starts at once.
            S_HOLD: begin
                if (transfer) begin
                    inst_valid_d = 1'b0;
                    num_inst_d   = num_inst_q + WORD_ONE;
                    pc_d         = pc_next;
                    state_d      = S_REQ;
                end
            end

            // The unit stays here until reset_cpu.
            S_ERR: begin
                inst_valid_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            num_inst_q   <= '0;
            fetch_err_q  <= 1'b0;
            tmo_cnt_q    <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so all
            // flops sample their _d values from the same pre-edge snapshot.
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            num_inst_q   <= num_inst_d;
            fetch_err_q  <= fetch_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // Outputs are decoded from registered state, so they are glitch-free and
    // go quiet as soon as reset is asserted.
    assign imem_req     = (state_q == S_REQ);
    assign imem_addr    = pc_q;
    assign inst         = inst_q;
    assign inst_valid   = inst_valid_q;
    assign pc           = pc_q;
    assign PC_below8bit = pc_q[7:0];
    assign num_inst     = num_inst_q;
    assign fetch_err    = fetch_err_q;

endmodule
